// File: rtl/adc_lane_deserializer.sv
// Multi-channel, multi-lane serial ADC deserialiser with frame-alignment tracking
// (hunt/acquire/locked), misplaced/missing FRAME edge detection and a saturating error counter.
module adc_lane_deserializer #(
  parameter int NUM_CHANNELS = 4,
  parameter int SAMPLE_WIDTH = 14,
  parameter int LANES        = 2,
  parameter int FRAME_BITS   = 8,
  parameter int LOCK_FRAMES  = 2
) (
  input  logic                                 data_clk_i,
  input  logic                                 reset_n_i,
  input  logic                                 frame_i,
  input  logic [NUM_CHANNELS*LANES-1:0]        ch_lanes_i,
  input  logic                                 err_clear_i,
  output logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] data_o,
  output logic                                 data_valid_o,
  output logic                                 locked_o,
  output logic                                 frame_err_o,
  output logic [7:0]                           err_count_o
);

  localparam int DSLOTS = SAMPLE_WIDTH / LANES;
  localparam int CW     = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam int DW     = NUM_CHANNELS * SAMPLE_WIDTH;

  localparam logic [CW-1:0] LAST_SLOT = CW'(FRAME_BITS - 1);
  localparam logic [CW-1:0] LAST_DATA = CW'(DSLOTS - 1);
  localparam logic [3:0]    LOCK_N    = 4'(LOCK_FRAMES);

  localparam logic [1:0] HUNT    = 2'd0;
  localparam logic [1:0] ACQUIRE = 2'd1;
  localparam logic [1:0] LOCKED  = 2'd2;

  logic          frame_q;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    good_q, good_d;
  logic [DW-1:0] shift_q, shift_d;
  logic [DW-1:0] data_q, data_d;
  logic [DW-1:0] word;
  logic          valid_q, valid_d;
  logic          err_flag_q, err_flag_d;
  logic [7:0]    err_cnt_q, err_cnt_d;

  logic          frame_rise;
  logic          active;
  logic          misplaced;
  logic          missing;
  logic          err_now;
  logic          capture;
  logic          transfer;
  logic [CW-1:0] slot;
  logic [CW-1:0] slot_next;
  logic [3:0]    good_inc;

  // cnt_q holds the slot predicted for this cycle; a FRAME rise forces the current slot to 0.
  always_comb begin
    frame_rise = frame_i & ~frame_q;
    active     = (state_q != HUNT);
    misplaced  = active & frame_rise & (cnt_q != '0);
    missing    = active & ~frame_rise & (cnt_q == '0);
    err_now    = misplaced | missing;
    slot       = frame_rise ? '0 : cnt_q;
    slot_next  = (slot == LAST_SLOT) ? '0 : slot + 1'b1;
    capture    = (active | frame_rise) & (slot <= LAST_DATA);
    transfer   = (state_q == LOCKED) & ~err_now & (slot == LAST_DATA);
    good_inc   = good_q + 4'd1;
  end

  // Lane 0 lands on the higher bit of each slot's group, so the word fills MSB first.
  always_comb begin
    word = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      word[c*SAMPLE_WIDTH +: SAMPLE_WIDTH] = shift_q[c*SAMPLE_WIDTH +: SAMPLE_WIDTH] << LANES;
      for (int l = 0; l < LANES; l++) begin
        word[c*SAMPLE_WIDTH + LANES - 1 - l] = ch_lanes_i[c*LANES + l];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    good_d  = good_q;
    case (state_q)
      HUNT: begin
        cnt_d = '0;
        if (frame_rise) begin
          state_d = ACQUIRE;
          cnt_d   = slot_next;
          good_d  = '0;
        end
      end
      ACQUIRE, LOCKED: begin
        if (missing) begin
          state_d = HUNT;
          cnt_d   = '0;
          good_d  = '0;
        end else if (misplaced) begin
          state_d = ACQUIRE;
          cnt_d   = slot_next;
          good_d  = '0;
        end else begin
          cnt_d = slot_next;
          if (frame_rise && (state_q == ACQUIRE)) begin
            good_d = good_inc;
            if (good_inc >= LOCK_N) begin
              state_d = LOCKED;
            end
          end
        end
      end
      default: begin
        state_d = HUNT;
        cnt_d   = '0;
        good_d  = '0;
      end
    endcase
  end

  // A clear coincident with a new error leaves exactly that one error recorded.
  always_comb begin
    shift_d = capture ? word : shift_q;
    data_d  = transfer ? word : data_q;
    valid_d = transfer;
    if (err_clear_i) begin
      err_flag_d = err_now;
      err_cnt_d  = err_now ? 8'd1 : 8'd0;
    end else begin
      err_flag_d = err_flag_q | err_now;
      err_cnt_d  = (err_now && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;
    end
  end

  // frame_q resets high so a FRAME already high at reset release is not taken as an edge.
  always_ff @(posedge data_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      frame_q    <= 1'b1;
      state_q    <= HUNT;
      cnt_q      <= '0;
      good_q     <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      err_flag_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      frame_q    <= frame_i;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      good_q     <= good_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      err_flag_q <= err_flag_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign data_o       = data_q;
  assign data_valid_o = valid_q;
  assign locked_o     = (state_q == LOCKED) & ~err_now;
  assign frame_err_o  = err_flag_q;
  assign err_count_o  = err_cnt_q;

endmodule

// File: tb/tb_adc_lane_deserializer.sv
// Directed bench for adc_lane_deserializer: default 4ch/2-lane instance plus a 1ch/1-lane/8-bit instance.
module tb_adc_lane_deserializer;

  localparam int NCH = 4;
  localparam int SW  = 14;
  localparam int NL  = 2;

  localparam logic [55:0] EXP_A = {42'd0, 14'h2AAA};
  localparam logic [55:0] EXP_B = {42'd0, 14'h2BBB};

  logic        clk = 1'b0;
  logic        resetN;
  logic        frame;
  logic [7:0]  lanes;
  logic        errClear;
  logic [55:0] data;
  logic        dataValid;
  logic        locked;
  logic        frameErr;
  logic [7:0]  errCount;

  logic        frame2;
  logic [0:0]  lane2;
  logic [7:0]  data2;
  logic        dataValid2;
  logic        locked2;
  logic        frameErr2;
  logic [7:0]  errCount2;

  int          assertCount = 0;
  int          failCount   = 0;
  int          validCount  = 0;
  int          valid2Count = 0;
  logic [55:0] lastData    = '0;
  logic [7:0]  lastData2   = '0;
  logic        lockedMid   = 1'b0;

  always #5 clk = ~clk;

  adc_lane_deserializer dut (
    .data_clk_i  (clk),
    .reset_n_i   (resetN),
    .frame_i     (frame),
    .ch_lanes_i  (lanes),
    .err_clear_i (errClear),
    .data_o      (data),
    .data_valid_o(dataValid),
    .locked_o    (locked),
    .frame_err_o (frameErr),
    .err_count_o (errCount)
  );

  adc_lane_deserializer #(
    .NUM_CHANNELS(1),
    .SAMPLE_WIDTH(8),
    .LANES       (1),
    .FRAME_BITS  (8),
    .LOCK_FRAMES (2)
  ) dutNarrow (
    .data_clk_i  (clk),
    .reset_n_i   (resetN),
    .frame_i     (frame2),
    .ch_lanes_i  (lane2),
    .err_clear_i (errClear),
    .data_o      (data2),
    .data_valid_o(dataValid2),
    .locked_o    (locked2),
    .frame_err_o (frameErr2),
    .err_count_o (errCount2)
  );

  always @(negedge clk) begin
    if (dataValid) begin
      validCount <= validCount + 1;
      lastData   <= data;
    end
    if (dataValid2) begin
      valid2Count <= valid2Count + 1;
      lastData2   <= data2;
    end
  end

  // Drives one frame of len slots: FRAME high for slots 0..3, lanes carry samples MSB first.
  task automatic applyStimulus(input logic [55:0] samples, input logic [7:0] mask,
                               input int len, input int clrSlot);
    logic [7:0] l;
    for (int k = 0; k < len; k++) begin
      frame    = (k < 4);
      errClear = (k == clrSlot);
      for (int c = 0; c < NCH; c++) begin
        for (int ln = 0; ln < NL; ln++) begin
          l[c*NL+ln] = (k < SW/NL) ? samples[c*SW + SW-1-(k*NL+ln)] : 1'b0;
        end
      end
      lanes = l & mask;
      if (k == 3) begin
        @(negedge clk);
        lockedMid = locked;
      end
      @(posedge clk);
      #1;
    end
    errClear = 1'b0;
  endtask

  task automatic idle(input int n, input logic level);
    frame = level;
    lanes = '0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sendNarrow(input logic [7:0] s);
    for (int k = 0; k < 8; k++) begin
      frame2   = (k < 4);
      lane2[0] = s[7-k];
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    assertCount++; if (data !== 56'd0) begin failCount++; $display("[TB] FAIL reset_data: got %h, expected %h", data, 56'd0); end
    assertCount++; if (dataValid !== 1'b0) begin failCount++; $display("[TB] FAIL reset_valid: got %b, expected 0", dataValid); end
    assertCount++; if (locked !== 1'b0) begin failCount++; $display("[TB] FAIL reset_locked: got %b, expected 0", locked); end
    assertCount++; if (frameErr !== 1'b0) begin failCount++; $display("[TB] FAIL reset_frame_err: got %b, expected 0", frameErr); end
    assertCount++; if (errCount !== 8'd0) begin failCount++; $display("[TB] FAIL reset_err_count: got %0d, expected 0", errCount); end
  endtask

  task automatic test_narrow_lane();
    int v0;
    v0 = valid2Count;
    sendNarrow(8'hA5);
    sendNarrow(8'hA5);
    sendNarrow(8'hA5);
    frame2 = 1'b0;
    lane2  = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    assertCount++; if (valid2Count - v0 !== 1) begin failCount++; $display("[TB] FAIL narrow_valid_count: got %0d, expected 1", valid2Count - v0); end
    assertCount++; if (lastData2 !== 8'hA5) begin failCount++; $display("[TB] FAIL narrow_data: got %h, expected a5", lastData2); end
  endtask

  task automatic test_basic_capture();
    int v0;
    v0 = validCount;
    applyStimulus(EXP_A, 8'hFF, 8, -1);
    applyStimulus(EXP_A, 8'hFF, 8, -1);
    assertCount++; if (lockedMid !== 1'b0) begin failCount++; $display("[TB] FAIL basic_locked_early: got %b, expected 0", lockedMid); end
    assertCount++; if (validCount - v0 !== 0) begin failCount++; $display("[TB] FAIL basic_valid_acquire: got %0d, expected 0", validCount - v0); end
    applyStimulus(EXP_A, 8'hFF, 8, -1);
    assertCount++; if (lockedMid !== 1'b1) begin failCount++; $display("[TB] FAIL basic_locked: got %b, expected 1", lockedMid); end
    assertCount++; if (validCount - v0 !== 1) begin failCount++; $display("[TB] FAIL basic_valid_first: got %0d, expected 1", validCount - v0); end
    assertCount++; if (lastData !== EXP_A) begin failCount++; $display("[TB] FAIL basic_data_a: got %h, expected %h", lastData, EXP_A); end
    applyStimulus(EXP_B, 8'hFF, 8, -1);
    assertCount++; if (validCount - v0 !== 2) begin failCount++; $display("[TB] FAIL basic_valid_second: got %0d, expected 2", validCount - v0); end
    assertCount++; if (lastData !== EXP_B) begin failCount++; $display("[TB] FAIL basic_data_b: got %h, expected %h", lastData, EXP_B); end
    assertCount++; if (errCount !== 8'd0) begin failCount++; $display("[TB] FAIL basic_err_count: got %0d, expected 0", errCount); end
  endtask

  task automatic test_lane_mapping();
    int v0;
    v0 = validCount;
    applyStimulus({14'h3FFF, 42'd0}, 8'h7F, 8, -1);
    assertCount++; if (validCount - v0 !== 1) begin failCount++; $display("[TB] FAIL lane_valid: got %0d, expected 1", validCount - v0); end
    assertCount++; if (lastData[55:42] !== 14'h2AAA) begin failCount++; $display("[TB] FAIL lane_ch3: got %h, expected 2aaa", lastData[55:42]); end
    assertCount++; if (lastData[41:0] !== 42'd0) begin failCount++; $display("[TB] FAIL lane_others: got %h, expected 0", lastData[41:0]); end
  endtask

  task automatic test_misplaced_edge();
    int v0;
    v0 = validCount;
    applyStimulus(EXP_A, 8'hFF, 5, -1);
    applyStimulus(EXP_B, 8'hFF, 8, -1);
    assertCount++; if (lockedMid !== 1'b0) begin failCount++; $display("[TB] FAIL mis_locked_drop: got %b, expected 0", lockedMid); end
    assertCount++; if (validCount - v0 !== 0) begin failCount++; $display("[TB] FAIL mis_no_valid: got %0d, expected 0", validCount - v0); end
    assertCount++; if (errCount !== 8'd1) begin failCount++; $display("[TB] FAIL mis_err_count: got %0d, expected 1", errCount); end
    assertCount++; if (frameErr !== 1'b1) begin failCount++; $display("[TB] FAIL mis_frame_err: got %b, expected 1", frameErr); end
    applyStimulus(EXP_B, 8'hFF, 8, -1);
    assertCount++; if (lockedMid !== 1'b0) begin failCount++; $display("[TB] FAIL mis_relock_early: got %b, expected 0", lockedMid); end
    applyStimulus(EXP_A, 8'hFF, 8, -1);
    assertCount++; if (lockedMid !== 1'b1) begin failCount++; $display("[TB] FAIL mis_relock: got %b, expected 1", lockedMid); end
    assertCount++; if (validCount - v0 !== 1) begin failCount++; $display("[TB] FAIL mis_relock_valid: got %0d, expected 1", validCount - v0); end
    assertCount++; if (lastData !== EXP_A) begin failCount++; $display("[TB] FAIL mis_relock_data: got %h, expected %h", lastData, EXP_A); end
  endtask

  task automatic test_missing_edge();
    int v0;
    v0 = validCount;
    applyStimulus(EXP_B, 8'hFF, 8, 2);
    assertCount++; if (errCount !== 8'd0) begin failCount++; $display("[TB] FAIL clr_err_count: got %0d, expected 0", errCount); end
    assertCount++; if (frameErr !== 1'b0) begin failCount++; $display("[TB] FAIL clr_frame_err: got %b, expected 0", frameErr); end
    assertCount++; if (lastData !== EXP_B) begin failCount++; $display("[TB] FAIL clr_frame_data: got %h, expected %h", lastData, EXP_B); end
    v0 = validCount;
    idle(16, 1'b0);
    assertCount++; if (errCount !== 8'd1) begin failCount++; $display("[TB] FAIL miss_err_count: got %0d, expected 1", errCount); end
    assertCount++; if (frameErr !== 1'b1) begin failCount++; $display("[TB] FAIL miss_frame_err: got %b, expected 1", frameErr); end
    assertCount++; if (locked !== 1'b0) begin failCount++; $display("[TB] FAIL miss_locked: got %b, expected 0", locked); end
    assertCount++; if (validCount - v0 !== 0) begin failCount++; $display("[TB] FAIL miss_no_valid: got %0d, expected 0", validCount - v0); end
    applyStimulus(EXP_A, 8'hFF, 8, -1);
    applyStimulus(EXP_A, 8'hFF, 8, -1);
    assertCount++; if (lockedMid !== 1'b0) begin failCount++; $display("[TB] FAIL miss_relock_early: got %b, expected 0", lockedMid); end
    applyStimulus(EXP_B, 8'hFF, 8, -1);
    assertCount++; if (lockedMid !== 1'b1) begin failCount++; $display("[TB] FAIL miss_relock: got %b, expected 1", lockedMid); end
    assertCount++; if (lastData !== EXP_B) begin failCount++; $display("[TB] FAIL miss_relock_data: got %h, expected %h", lastData, EXP_B); end
    assertCount++; if (errCount !== 8'd1) begin failCount++; $display("[TB] FAIL miss_err_hold: got %0d, expected 1", errCount); end
  endtask

  task automatic test_saturation_clear();
    lanes = '0;
    for (int i = 0; i < 262; i++) begin
      frame = 1'b1;
      @(posedge clk);
      #1;
      frame = 1'b0;
      @(posedge clk);
      #1;
    end
    assertCount++; if (errCount !== 8'd255) begin failCount++; $display("[TB] FAIL sat_err_count: got %0d, expected 255", errCount); end
    assertCount++; if (frameErr !== 1'b1) begin failCount++; $display("[TB] FAIL sat_frame_err: got %b, expected 1", frameErr); end
    errClear = 1'b1;
    @(posedge clk);
    #1;
    errClear = 1'b0;
    assertCount++; if (errCount !== 8'd0) begin failCount++; $display("[TB] FAIL clear_err_count: got %0d, expected 0", errCount); end
    assertCount++; if (frameErr !== 1'b0) begin failCount++; $display("[TB] FAIL clear_frame_err: got %b, expected 0", frameErr); end
    frame    = 1'b1;
    errClear = 1'b1;
    @(posedge clk);
    #1;
    errClear = 1'b0;
    assertCount++; if (errCount !== 8'd1) begin failCount++; $display("[TB] FAIL clear_coincident_count: got %0d, expected 1", errCount); end
    assertCount++; if (frameErr !== 1'b1) begin failCount++; $display("[TB] FAIL clear_coincident_flag: got %b, expected 1", frameErr); end
  endtask

  task automatic test_reset_mid_frame();
    int v0;
    idle(1, 1'b0);
    applyStimulus(EXP_A, 8'hFF, 8, -1);
    applyStimulus(EXP_A, 8'hFF, 8, -1);
    applyStimulus(EXP_B, 8'hFF, 8, -1);
    assertCount++; if (lockedMid !== 1'b1) begin failCount++; $display("[TB] FAIL rst_pre_locked: got %b, expected 1", lockedMid); end
    applyStimulus(EXP_A, 8'hFF, 4, -1);
    frame  = 1'b1;
    resetN = 1'b0;
    #1;
    test_reset();
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    v0     = validCount;
    resetN = 1'b1;
    idle(12, 1'b1);
    assertCount++; if (errCount !== 8'd0) begin failCount++; $display("[TB] FAIL rst_no_edge_count: got %0d, expected 0", errCount); end
    assertCount++; if (frameErr !== 1'b0) begin failCount++; $display("[TB] FAIL rst_no_edge_flag: got %b, expected 0", frameErr); end
    assertCount++; if (locked !== 1'b0) begin failCount++; $display("[TB] FAIL rst_no_edge_locked: got %b, expected 0", locked); end
    assertCount++; if (validCount - v0 !== 0) begin failCount++; $display("[TB] FAIL rst_no_valid: got %0d, expected 0", validCount - v0); end
    idle(1, 1'b0);
    applyStimulus(EXP_B, 8'hFF, 8, -1);
    applyStimulus(EXP_B, 8'hFF, 8, -1);
    applyStimulus(EXP_A, 8'hFF, 8, -1);
    assertCount++; if (lockedMid !== 1'b1) begin failCount++; $display("[TB] FAIL rst_relock: got %b, expected 1", lockedMid); end
    assertCount++; if (validCount - v0 !== 1) begin failCount++; $display("[TB] FAIL rst_relock_valid: got %0d, expected 1", validCount - v0); end
    assertCount++; if (lastData !== EXP_A) begin failCount++; $display("[TB] FAIL rst_relock_data: got %h, expected %h", lastData, EXP_A); end
    assertCount++; if (errCount !== 8'd0) begin failCount++; $display("[TB] FAIL rst_relock_err: got %0d, expected 0", errCount); end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    resetN   = 1'b0;
    frame    = 1'b0;
    lanes    = '0;
    errClear = 1'b0;
    frame2   = 1'b0;
    lane2    = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    test_reset();
    resetN = 1'b1;
    idle(2, 1'b0);
    test_narrow_lane();
    test_basic_capture();
    test_lane_mapping();
    test_misplaced_edge();
    test_missing_edge();
    test_saturation_clear();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/adc_lane_deserializer.md
# adc_lane_deserializer

Parametrised, multi-channel successor to the quad ADC serial interface. It deserialises SAMPLE_WIDTH-bit samples from NUM_CHANNELS serial ADC channels, each carried on LANES interleaved single-rate lanes, framed by a shared FRAME signal. It adds frame-alignment tracking (hunt, acquire, locked), misplaced-edge and missing-edge detection, and a saturating error counter. It sits between the ADC pin interface and the sample FIFO / AXI capture logic.

## Interface
- NUM_CHANNELS, 4: number of ADC channels, 1..8.
- SAMPLE_WIDTH, 14: bits per sample; must be divisible by LANES.
- LANES, 2: serial lanes per channel, 1 or 2.
- FRAME_BITS, 8: DATA_CLK cycles per frame; must be >= SAMPLE_WIDTH/LANES. Trailing slots are padding and ignored.
- LOCK_FRAMES, 2: consecutive well-formed frames required to enter LOCKED, 1..15.

Ports:
- DATA_CLK  in  1  bit clock; all logic uses the rising edge. One clock, no other domains.
- RESET_N  in  1  asynchronous, active-low reset.
- FRAME  in  1  frame marker, sampled as data. A rising edge marks slot 0.
- CH_LANES  in  NUM_CHANNELS*LANES  serial lanes; channel c, lane l at bit c*LANES+l.
- ERR_CLEAR  in  1  synchronous clear of FRAME_ERR and ERR_COUNT.
- DATA  out  NUM_CHANNELS*SAMPLE_WIDTH  parallel samples; channel c at bits [c*SAMPLE_WIDTH +: SAMPLE_WIDTH].
- DATA_VALID  out  1  one-cycle pulse; DATA holds a new, complete set of samples.
- LOCKED  out  1  high while the FSM is in LOCKED.
- FRAME_ERR  out  1  sticky; set by any framing error.
- ERR_COUNT  out  8  framing errors since reset/clear; saturates at 255.

## Operation
- Edge detect: frame_q <= FRAME; frame_rise = FRAME & ~frame_q. On reset frame_q = 1, so FRAME already high at reset release does not count as an edge.
- Slot counter cnt, range 0..FRAME_BITS-1:
  - cnt = 0 on the cycle frame_rise is seen; it increments every cycle after that and wraps.
  - For D = SAMPLE_WIDTH/LANES, slot k < D on lane l carries sample bit SAMPLE_WIDTH-1-(k*LANES+l) (MSB first; lane 0 takes the higher bit).
  - Slots k >= D are ignored.
- Per-channel shift register: captures each lane bit at slots 0..D-1. When slot D-1 completes, the sample is transferred to DATA only in LOCKED.
- FSM states:
  - HUNT: cnt idle, no capture. frame_rise -> ACQUIRE, with cnt = 0 and good = 0.
  - ACQUIRE: capture runs, but DATA is not updated. Each correctly placed frame_rise increments good; on reaching LOCK_FRAMES -> LOCKED.
  - LOCKED: capture runs and DATA/DATA_VALID update once per frame.
- Framing errors apply in ACQUIRE and LOCKED:
  - Misplaced edge: frame_rise with cnt != 0 expected. Resync cnt to 0 at this edge, discard the partial word, set good = 0, go to ACQUIRE, count one error.
  - Missing edge: the cycle after cnt = FRAME_BITS-1 has no frame_rise. Go to HUNT, discard the word, count one error.
- Errors set FRAME_ERR and increment ERR_COUNT, saturating at 255. If ERR_CLEAR and an error occur in the same cycle, the result is FRAME_ERR = 1, ERR_COUNT = 1.
- Reset (any time, including mid-frame): DATA = 0, DATA_VALID = 0, LOCKED = 0, FRAME_ERR = 0, ERR_COUNT = 0, state = HUNT, cnt = 0.

## Timing
- Slot k is sampled at the k-th rising edge after the edge that saw frame_rise (k = 0 on that edge).
- Latency: DATA and DATA_VALID are registered on the edge after slot D-1 is sampled. With defaults, DATA_VALID is high during slot 7. Sample-to-output latency is one cycle after the last data bit.
- DATA_VALID is high for exactly one cycle per frame in LOCKED. DATA is held between pulses.
- LOCKED rises in the same cycle as the state transition, i.e. the cycle after the LOCK_FRAMES-th correctly placed frame_rise is seen. The first DATA_VALID is for that frame.
- LOCKED falls on the cycle the error is detected. No DATA_VALID is produced for the discarded frame.
- ERR_COUNT and FRAME_ERR update one cycle after error detection.

## Test plan
- Basic capture (defaults):
  - Stimulus: FRAME period 8, 50% duty. Channel 0 sends 0x2AAA, then 0x2BBB; other channels send 0x0000.
  - Required: LOCKED after 2 frames; DATA_VALID pulses show ch0 = 0x2AAA, then 0x2BBB; ERR_COUNT = 0.
- Lane mapping:
  - Stimulus: ch3 sends 0x3FFF on lane 0 only, with lane 1 held at 0.
  - Required: ch3 = 0x2AAA.
  - Also run LANES = 1, SAMPLE_WIDTH = 8, FRAME_BITS = 8 with 0xA5, requiring 0xA5.
- Misplaced edge:
  - Stimulus: in LOCKED, one FRAME rising edge 3 cycles early.
  - Required: LOCKED drops; no DATA_VALID for the truncated frame; ERR_COUNT = 1; re-lock after 2 good frames.
- Missing edge:
  - Stimulus: hold FRAME low for 2 periods.
  - Required: HUNT, ERR_COUNT = 1, FRAME_ERR = 1; re-lock after the next edge plus 2 frames.
- Saturation and clear:
  - Stimulus: inject 260 misplaced edges.
  - Required: ERR_COUNT = 255. A single-cycle ERR_CLEAR gives ERR_COUNT = 0 and FRAME_ERR = 0. ERR_CLEAR coincident with an error gives ERR_COUNT = 1.
- Reset mid-frame:
  - Stimulus: assert RESET_N low at slot 4 while LOCKED, with FRAME high at release.
  - Required: all outputs 0 immediately; no edge counted until FRAME falls and rises again; clean re-lock.
